// File: rtl/pc_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg
//   Shared definitions for the program-counter / fetch-redirect controller:
//   control-transfer opcodes, FSM state and control-kind enums, and an
//   opcode classifier used by the top-level FSM.
// ----------------------------------------------------------------------------
package pc_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic {RUN, RESOLVE} pc_state_t;

   typedef enum logic [1:0] {NONE, JAL, JALR, BR} ctl_kind_t;

   function automatic ctl_kind_t decode_ctl(input logic [6:0] op);
      ctl_kind_t k;
      k = NONE;
      case (op)
         OP_JAL:    k = JAL;
         OP_JALR:   k = JALR;
         OP_BRANCH: k = BR;
         default:   k = NONE;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl_if
//   Fetch/decode-side bundle of the PC controller.
//   Inputs to the controller : stall_i, op_i, b_taken_i, offset_i, jalr_base_i
//   Outputs of the controller: ip_o, pc_def_o, fetch_valid_o, busy_o,
//                              misalign_o
//   master = the controller, slave = the surrounding pipeline.
// ----------------------------------------------------------------------------
interface pc_fetch_ctrl_if #(
   parameter int unsigned XLEN = 32
);
   logic            stall_i;
   logic [6:0]      op_i;
   logic            b_taken_i;
   logic [XLEN-1:0] offset_i;
   logic [XLEN-1:0] jalr_base_i;
   logic [XLEN-1:0] ip_o;
   logic [XLEN-1:0] pc_def_o;
   logic            fetch_valid_o;
   logic            busy_o;
   logic            misalign_o;

   modport master (
      input  stall_i, op_i, b_taken_i, offset_i, jalr_base_i,
      output ip_o, pc_def_o, fetch_valid_o, busy_o, misalign_o
   );

   modport slave (
      output stall_i, op_i, b_taken_i, offset_i, jalr_base_i,
      input  ip_o, pc_def_o, fetch_valid_o, busy_o, misalign_o
   );
endinterface

// File: rtl/pc_fetch_ctrl_target_calc.sv
// ----------------------------------------------------------------------------
// pc_target_calc
//   Combinational redirect-target computation.
//   Inputs : ctl_kind (latched control kind), ip_ctl (address of the control
//            op), offset (signed immediate), jalr_base (rs1), b_taken.
//   Outputs: next_ip  (resolved target or fall-through, modulo 2^XLEN)
//            misalign (taken target has target[1:0] != 0)
// ----------------------------------------------------------------------------
module pc_target_calc
   import pc_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned INC  = 4
) (
   input  ctl_kind_t       ctl_kind,
   input  logic [XLEN-1:0] ip_ctl,
   input  logic [XLEN-1:0] offset,
   input  logic [XLEN-1:0] jalr_base,
   input  logic            b_taken,
   output logic [XLEN-1:0] next_ip,
   output logic            misalign
);

   logic [XLEN-1:0] rel_tgt;
   logic [XLEN-1:0] abs_tgt;

   assign rel_tgt = ip_ctl + offset;
   // JALR target is absolute with bit 0 forced clear.
   assign abs_tgt = (jalr_base + offset) & ~XLEN'(1);

   always_comb begin
      next_ip  = ip_ctl + XLEN'(INC);
      misalign = 1'b0;
      case (ctl_kind)
         JAL: begin
            next_ip  = rel_tgt;
            misalign = |rel_tgt[1:0];
         end
         JALR: begin
            next_ip  = abs_tgt;
            misalign = |abs_tgt[1:0];
         end
         BR: begin
            // Not-taken fall-through is never alignment-checked.
            if (b_taken) begin
               next_ip  = rel_tgt;
               misalign = |rel_tgt[1:0];
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl
//   Program counter and fetch-redirect controller. Advances ip_o by INC each
//   unstalled RUN cycle; on JAL/JALR/BRANCH it enters RESOLVE for RESOLVE_CYC
//   bubble cycles, then redirects to the resolved target (or TRAP_VEC if the
//   taken target is misaligned).
//   Ports: CLK, RESET (synchronous, active-high), bus (pc_fetch_ctrl_if.master)
// ----------------------------------------------------------------------------
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VEC   = '0,
   parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h100),
   parameter int unsigned     INC         = 4,
   parameter int unsigned     RESOLVE_CYC = 1
) (
   input logic             CLK,
   input logic             RESET,
   pc_fetch_ctrl_if.master bus
);

   localparam int unsigned    CW       = (RESOLVE_CYC > 1) ? $clog2(RESOLVE_CYC) : 1;
   localparam logic [CW-1:0]  CNT_INIT = CW'(RESOLVE_CYC - 1);

   pc_state_t       state_q, state_d;
   ctl_kind_t       kind_q,  kind_d;
   ctl_kind_t       op_kind;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [XLEN-1:0] ip_q,    ip_d;
   logic [XLEN-1:0] ip_ctl_q, ip_ctl_d;
   logic [XLEN-1:0] tgt_ip;
   logic            tgt_mis;
   logic            fire;

   pc_target_calc #(
      .XLEN (XLEN),
      .INC  (INC)
   ) u_target_calc (
      .ctl_kind  (kind_q),
      .ip_ctl    (ip_ctl_q),
      .offset    (bus.offset_i),
      .jalr_base (bus.jalr_base_i),
      .b_taken   (bus.b_taken_i),
      .next_ip   (tgt_ip),
      .misalign  (tgt_mis)
   );

   // Resolve step happens only on the final, unstalled RESOLVE cycle.
   assign fire = (state_q == RESOLVE) && (cnt_q == '0) && !bus.stall_i;

   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      cnt_d    = cnt_q;
      ip_d     = ip_q;
      ip_ctl_d = ip_ctl_q;
      op_kind  = decode_ctl(bus.op_i);
      if (!bus.stall_i) begin
         case (state_q)
            RUN: begin
               if (op_kind != NONE) begin
                  ip_ctl_d = ip_q;
                  kind_d   = op_kind;
                  cnt_d    = CNT_INIT;
                  state_d  = RESOLVE;
               end else begin
                  ip_d = ip_q + XLEN'(INC);
               end
            end
            RESOLVE: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  ip_d    = tgt_mis ? TRAP_VEC : tgt_ip;
                  kind_d  = NONE;
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= RUN;
         kind_q   <= NONE;
         cnt_q    <= '0;
         ip_q     <= RESET_VEC;
         ip_ctl_q <= '0;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         cnt_q    <= cnt_d;
         ip_q     <= ip_d;
         ip_ctl_q <= ip_ctl_d;
      end
   end

   assign bus.ip_o          = ip_q;
   // During bubbles the link value comes from the latched control-op address.
   assign bus.pc_def_o      = (state_q == RESOLVE) ? (ip_ctl_q + XLEN'(INC))
                                                   : (ip_q + XLEN'(INC));
   assign bus.fetch_valid_o = (state_q == RUN) && !bus.stall_i;
   assign bus.busy_o        = (state_q == RESOLVE);
   // Gated by RESET so a reset landing on the resolve edge shows no pulse.
   assign bus.misalign_o    = fire && tgt_mis && !RESET;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//   Self-checking bench for pc_fetch_ctrl. Two instances: RESOLVE_CYC=1 and
//   RESOLVE_CYC=3, driven with identical inputs; each expectation names the
//   instance it applies to. Inputs change 1 time unit after posedge, the
//   expected per-cycle outputs are queued at the same moment and compared at
//   the following negedge.
// ----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;
   import pc_pkg::*;

   localparam logic [6:0] NOP = 7'b0010011;

   typedef struct {
      string       tag;
      bit          sel;
      logic [31:0] ip;
      logic        v;
      logic        b;
      logic [31:0] pd;
      logic        m;
   } exp_t;

   logic CLK = 1'b0;
   logic RESET;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   pc_fetch_ctrl_if #(.XLEN(32)) bus1 ();
   pc_fetch_ctrl_if #(.XLEN(32)) bus3 ();

   pc_fetch_ctrl #(
      .XLEN        (32),
      .RESET_VEC   (32'h0),
      .TRAP_VEC    (32'h100),
      .INC         (4),
      .RESOLVE_CYC (1)
   ) dut1 (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus1.master)
   );

   pc_fetch_ctrl #(
      .XLEN        (32),
      .RESET_VEC   (32'h0),
      .TRAP_VEC    (32'h100),
      .INC         (4),
      .RESOLVE_CYC (3)
   ) dut3 (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus3.master)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit rst, input bit stall, input logic [6:0] op,
                       input bit bt, input logic [31:0] off, input logic [31:0] base);
      @(posedge CLK);
      #1;
      RESET            = rst;
      bus1.stall_i     = stall;  bus3.stall_i     = stall;
      bus1.op_i        = op;     bus3.op_i        = op;
      bus1.b_taken_i   = bt;     bus3.b_taken_i   = bt;
      bus1.offset_i    = off;    bus3.offset_i    = off;
      bus1.jalr_base_i = base;   bus3.jalr_base_i = base;
   endtask

   task automatic expect_o(input string tag, input bit sel, input logic [31:0] ip,
                           input logic v, input logic b, input logic [31:0] pd,
                           input logic m);
      exp_t e;
      e.tag = tag; e.sel = sel; e.ip = ip; e.v = v; e.b = b; e.pd = pd; e.m = m;
      sb.push_back(e);
   endtask

   always @(negedge CLK) begin : monitor
      exp_t        e;
      logic [31:0] o_ip, o_pd;
      logic        o_v, o_b, o_m;
      if (sb.size() != 0) begin
         e    = sb.pop_front();
         o_ip = e.sel ? bus3.ip_o          : bus1.ip_o;
         o_pd = e.sel ? bus3.pc_def_o      : bus1.pc_def_o;
         o_v  = e.sel ? bus3.fetch_valid_o : bus1.fetch_valid_o;
         o_b  = e.sel ? bus3.busy_o        : bus1.busy_o;
         o_m  = e.sel ? bus3.misalign_o    : bus1.misalign_o;
         chk({e.tag, ".ip"},     o_ip,      e.ip);
         chk({e.tag, ".valid"},  32'(o_v),  32'(e.v));
         chk({e.tag, ".busy"},   32'(o_b),  32'(e.b));
         chk({e.tag, ".pcdef"},  o_pd,      e.pd);
         chk({e.tag, ".mis"},    32'(o_m),  32'(e.m));
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      RESET = 1'b1;
      bus1.stall_i = 1'b0; bus1.op_i = NOP; bus1.b_taken_i = 1'b0;
      bus1.offset_i = '0;  bus1.jalr_base_i = '0;
      bus3.stall_i = 1'b0; bus3.op_i = NOP; bus3.b_taken_i = 1'b0;
      bus3.offset_i = '0;  bus3.jalr_base_i = '0;

      // ---------------- RESOLVE_CYC = 1 instance ----------------
      step(1, 0, NOP, 0, 0, 0);
      step(1, 0, NOP, 0, 0, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("rst0",    0, 32'h00, 1, 0, 32'h04, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("seq1",    0, 32'h04, 1, 0, 32'h08, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("seq2",    0, 32'h08, 1, 0, 32'h0C, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("seq3",    0, 32'h0C, 1, 0, 32'h10, 0);
      step(0, 0, OP_JAL, 0, 0, 0);       expect_o("jal_op",  0, 32'h10, 1, 0, 32'h14, 0);
      // op_i ignored during RESOLVE: a second JAL here must not matter
      step(0, 0, OP_JAL, 0, 32'h20, 0);  expect_o("jal_bub", 0, 32'h10, 0, 1, 32'h14, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("jal_tgt", 0, 32'h30, 1, 0, 32'h34, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("seq34",   0, 32'h34, 1, 0, 32'h38, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("seq38",   0, 32'h38, 1, 0, 32'h3C, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("seq3c",   0, 32'h3C, 1, 0, 32'h40, 0);
      step(0, 0, OP_BRANCH, 0, 0, 0);    expect_o("br_nt",   0, 32'h40, 1, 0, 32'h44, 0);
      step(0, 0, NOP, 0, 32'h7777_0000, 0);
                                         expect_o("br_ntb",  0, 32'h40, 0, 1, 32'h44, 0);
      step(0, 0, OP_BRANCH, 0, 0, 0);    expect_o("br_t",    0, 32'h44, 1, 0, 32'h48, 0);
      step(0, 0, NOP, 1, 32'hFFFF_FFF8, 0);
                                         expect_o("br_tb",   0, 32'h44, 0, 1, 32'h48, 0);
      step(0, 0, OP_JALR, 0, 0, 0);      expect_o("br_tgt",  0, 32'h3C, 1, 0, 32'h40, 0);
      // 0x1001 + 3 = 0x1004, bit 0 already clear after the add
      step(0, 0, NOP, 0, 32'h3, 32'h1001);
                                         expect_o("jalr_b",  0, 32'h3C, 0, 1, 32'h40, 0);
      step(0, 0, OP_JALR, 0, 0, 0);      expect_o("jalr_t",  0, 32'h1004, 1, 0, 32'h1008, 0);
      // 0x1000 + 2 = 0x1002: bit 1 set, must trap
      step(0, 0, NOP, 0, 32'h2, 32'h1000);
                                         expect_o("mis_b",   0, 32'h1004, 0, 1, 32'h1008, 1);
      step(0, 1, OP_JAL, 0, 0, 0);       expect_o("trap_st", 0, 32'h100, 0, 0, 32'h104, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("trap_go", 0, 32'h100, 1, 0, 32'h104, 0);
      step(0, 0, OP_JAL, 0, 0, 0);       expect_o("jal2",    0, 32'h104, 1, 0, 32'h108, 0);
      // reset arrives on the resolve cycle with a misaligned target pending
      step(1, 0, NOP, 0, 32'h2, 0);      expect_o("rst_mid", 0, 32'h104, 0, 1, 32'h108, 0);
      step(0, 0, NOP, 0, 32'h2, 0);      expect_o("rst_aft", 0, 32'h00, 1, 0, 32'h04, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("rst_s1",  0, 32'h04, 1, 0, 32'h08, 0);
      step(0, 0, OP_JAL, 0, 0, 0);       expect_o("wrap_op", 0, 32'h08, 1, 0, 32'h0C, 0);
      step(0, 0, NOP, 0, 32'hFFFF_FFF4, 0);
                                         expect_o("wrap_b",  0, 32'h08, 0, 1, 32'h0C, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("wrap_t",  0, 32'hFFFF_FFFC, 1, 0, 32'h0, 0);

      // ---------------- RESOLVE_CYC = 3 instance ----------------
      step(1, 0, NOP, 0, 0, 0);
      step(1, 0, NOP, 0, 0, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("r3_rst",  1, 32'h00, 1, 0, 32'h04, 0);
      step(0, 0, OP_JAL, 0, 0, 0);       expect_o("r3_jal",  1, 32'h04, 1, 0, 32'h08, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("r3_b2",   1, 32'h04, 0, 1, 32'h08, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("r3_b1",   1, 32'h04, 0, 1, 32'h08, 0);
      step(0, 0, NOP, 0, 32'h10, 0);     expect_o("r3_b0",   1, 32'h04, 0, 1, 32'h08, 0);
      step(0, 0, OP_BRANCH, 0, 0, 0);    expect_o("r3_tgt",  1, 32'h14, 1, 0, 32'h18, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("st_c2",   1, 32'h14, 0, 1, 32'h18, 0);
      step(0, 1, NOP, 1, 32'h2C, 0);     expect_o("st_h1",   1, 32'h14, 0, 1, 32'h18, 0);
      step(0, 1, NOP, 1, 32'h2C, 0);     expect_o("st_h2",   1, 32'h14, 0, 1, 32'h18, 0);
      step(0, 0, NOP, 1, 32'h2C, 0);     expect_o("st_c1",   1, 32'h14, 0, 1, 32'h18, 0);
      step(0, 0, NOP, 1, 32'h2C, 0);     expect_o("st_c0",   1, 32'h14, 0, 1, 32'h18, 0);
      step(0, 0, OP_JAL, 0, 0, 0);       expect_o("st_tgt",  1, 32'h40, 1, 0, 32'h44, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("ms_c2",   1, 32'h40, 0, 1, 32'h44, 0);
      step(0, 0, NOP, 0, 0, 0);          expect_o("ms_c1",   1, 32'h40, 0, 1, 32'h44, 0);
      step(0, 1, NOP, 0, 32'h6, 0);      expect_o("ms_stl",  1, 32'h40, 0, 1, 32'h44, 0);
      step(0, 0, NOP, 0, 32'h6, 0);      expect_o("ms_c0",   1, 32'h40, 0, 1, 32'h44, 1);
      step(0, 0, NOP, 0, 0, 0);          expect_o("ms_trap", 1, 32'h100, 1, 0, 32'h104, 0);

      @(negedge CLK);
      #1;
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Parametrised program-counter and fetch-redirect controller for the single-issue core. Sits between instruction memory and decode.
- Advances IP by a fixed increment each cycle. On JAL, JALR or conditional branch it inserts a configurable number of resolution bubbles, then redirects to the resolved target.
- Adds what the first-generation PC lacked: hazard freeze, configurable resolve latency, absolute JALR targets, misaligned-target trap redirect, and a fetch-valid qualifier.

Parameters:
- XLEN, 32, address/data width.
- RESET_VEC, 0, IP value after reset.
- TRAP_VEC, 32'h100, IP loaded on misaligned target.
- INC, 4, sequential increment.
- RESOLVE_CYC, 1, bubble cycles per control transfer (>=1).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard freeze; holds all state.
- op_i  in  7  opcode of the instruction currently at ip_o.
- b_taken_i  in  1  branch condition result; valid on the last RESOLVE cycle.
- offset_i  in  XLEN  signed immediate; valid on the last RESOLVE cycle.
- jalr_base_i  in  XLEN  rs1 value for JALR; valid on the last RESOLVE cycle.
- ip_o  out  XLEN  current fetch address.
- pc_def_o  out  XLEN  link/fall-through address.
- fetch_valid_o  out  1  ip_o holds a real instruction.
- busy_o  out  1  in RESOLVE.
- misalign_o  out  1  one-cycle pulse on misaligned redirect.

Behaviour:
- Clock is CLK; RESET is synchronous and active-high.
- RESET (sampled high at a posedge, including mid-RESOLVE):
  - ip_o=RESET_VEC, state=RUN, counter=0, ctl_kind=NONE.
  - misalign_o=0, fetch_valid_o=1 the following cycle.
- States are RUN and RESOLVE.
- RUN, stall_i=0:
  - op_i not a control op: ip_o <= ip_o+INC.
  - op_i=1101111 (JAL), 1100111 (JALR) or 1100011 (BRANCH):
    - latch ip_ctl<=ip_o and ctl_kind; cnt<=RESOLVE_CYC-1.
    - ip_o holds; state->RESOLVE.
- RESOLVE:
  - fetch_valid_o=0 and busy_o=1 throughout; op_i is ignored.
  - cnt>0: cnt decrements.
  - cnt==0: compute target and next IP; state->RUN.
- Targets (wrap modulo 2^XLEN, no overflow flag):
  - JAL: ip_ctl+offset_i.
  - JALR: (jalr_base_i+offset_i) with bit0 cleared.
  - BRANCH taken: ip_ctl+offset_i.
  - BRANCH not taken: ip_ctl+INC.
- Redirect: taken target with target[1:0]!=0 -> ip_o<=TRAP_VEC, misalign_o=1 for exactly one cycle. Otherwise ip_o<=target.
- Not-taken fall-through is never checked for alignment.
- stall_i=1 (either state): ip_o, state, cnt and latches hold. misalign_o=0.
- stall_i has priority over the resolve step; RESET has priority over everything.
- fetch_valid_o:
  - RUN: equals !stall_i.
  - RESOLVE: 0.
- pc_def_o:
  - RUN: ip_o+INC (combinational).
  - RESOLVE: ip_ctl+INC, so the link value is stable during bubbles.
- Latency: a control op at cycle t gives the redirected ip_o at t+RESOLVE_CYC+1 (no stalls).
- Back-to-back control ops: the op at the redirect target is decoded normally in the first RUN cycle.

Decomposition:
- Package pc_pkg:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH.
  - enum pc_state_t {RUN, RESOLVE}.
  - enum ctl_kind_t {NONE, JAL, JALR, BR}.
- Sub-module pc_target_calc (combinational):
  - inputs ctl_kind, ip_ctl, offset, jalr_base, b_taken.
  - outputs next_ip and misalign.
- The top level holds the FSM, counter and registers.

Test Plan:
- RESET then 4 non-control ops -> ip_o = 0,4,8,12,16; fetch_valid_o=1 throughout.
- JAL at ip=0x10, offset=0x20, RESOLVE_CYC=1 -> one bubble (fetch_valid_o=0, pc_def_o=0x14), then ip_o=0x30.
- BRANCH at 0x40, b_taken=0, then a second BRANCH at 0x44 with b_taken=1, offset=-8 -> ip_o 0x44, then 0x3C.
- JALR, jalr_base=0x1001, offset=2 -> ip_o=0x1002. Separately jalr_base=0x1000, offset=2 -> ip_o=TRAP_VEC, misalign_o pulses once.
- RESOLVE_CYC=3, stall_i high for 2 cycles mid-RESOLVE -> redirect occurs exactly 2 cycles later than unstalled, counter preserved.
- RESET asserted during RESOLVE -> ip_o=RESET_VEC next cycle, busy_o=0, no redirect or misalign pulse afterwards.
